l1pa_regfile_loader: RTL and testbench



---
 rtl/l1pa_regfile_loader.sv | 134 +++++++++++++
 tb/tb_l1pa_regfile_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1pa_regfile_loader.sv
`default_nettype none
// ============================================================================
// Module   : l1pa_regfile_loader
// Brief    : Streams pages into the L1PA shift-pattern regfile type-0 write
//            port from a programmable base address, with completion status.
// Revision : 1.0 - initial release
// ============================================================================
module l1pa_regfile_loader #(
    parameter int PAGE_NUM   = 32,
    parameter int PAGE_WIDTH = 15,
    parameter int ADDR_WIDTH = $clog2(PAGE_NUM),
    parameter int CNT_WIDTH  = $clog2(PAGE_NUM + 1)
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  page_cnt_i,
    input  logic                  abort_i,
    input  logic [PAGE_WIDTH-1:0] pg_data_i,
    input  logic                  pg_valid_i,
    output logic                  pg_ready_o,
    output logic [ADDR_WIDTH-1:0] regType0_waddr_o,
    output logic [PAGE_WIDTH-1:0] regType0_wdata_o,
    output logic                  regType0_we_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  pages_written_o,
    output logic [PAGE_WIDTH-1:0] checksum_o,
    output logic                  cfg_err_o
);

    localparam logic [CNT_WIDTH-1:0]  c_PAGE_NUM_CNT = CNT_WIDTH'(PAGE_NUM);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR    = ADDR_WIDTH'(PAGE_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_WIDTH-1:0] r_curAddr;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [PAGE_WIDTH-1:0] r_wdata;
    logic [CNT_WIDTH-1:0]  r_pagesWritten;
    logic [PAGE_WIDTH-1:0] r_checksum;
    logic                  r_cfgErr;

    logic                  w_handshake;
    logic                  w_oversize;
    logic [CNT_WIDTH-1:0]  w_jobLen;
    logic [ADDR_WIDTH-1:0] w_nextAddr;

    // Oversized jobs are clamped to the regfile depth rather than rejected.
    assign w_oversize  = page_cnt_i > c_PAGE_NUM_CNT;
    assign w_jobLen    = w_oversize ? c_PAGE_NUM_CNT : page_cnt_i;
    assign w_nextAddr  = (r_curAddr == c_LAST_ADDR) ? '0 : r_curAddr + ADDR_WIDTH'(1);
    assign w_handshake = pg_valid_i && pg_ready_o;

    always_comb begin
        w_nextState = r_state;
        pg_ready_o  = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_nextState = (w_jobLen != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                busy_o     = 1'b1;
                pg_ready_o = !abort_i;
                if (abort_i) begin
                    w_nextState = S_IDLE;
                end else if (w_handshake && (r_remaining == CNT_WIDTH'(1))) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                busy_o      = 1'b1;
                done_o      = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_curAddr      <= '0;
            r_remaining    <= '0;
            r_we           <= 1'b0;
            r_waddr        <= '0;
            r_wdata        <= '0;
            r_pagesWritten <= '0;
            r_checksum     <= '0;
            r_cfgErr       <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_we    <= w_handshake;
            if ((r_state == S_IDLE) && start_i) begin
                r_curAddr      <= base_addr_i;
                r_remaining    <= w_jobLen;
                r_pagesWritten <= '0;
                r_checksum     <= '0;
                r_cfgErr       <= w_oversize;
            end
            // Start and handshake are mutually exclusive (IDLE vs LOAD).
            if (w_handshake) begin
                r_waddr        <= r_curAddr;
                r_wdata        <= pg_data_i;
                r_curAddr      <= w_nextAddr;
                r_remaining    <= r_remaining - CNT_WIDTH'(1);
                r_pagesWritten <= r_pagesWritten + CNT_WIDTH'(1);
                r_checksum     <= r_checksum ^ pg_data_i;
            end
        end
    end

    assign regType0_we_o    = r_we;
    assign regType0_waddr_o = r_waddr;
    assign regType0_wdata_o = r_wdata;
    assign pages_written_o  = r_pagesWritten;
    assign checksum_o       = r_checksum;
    assign cfg_err_o        = r_cfgErr;

endmodule
`default_nettype wire

// File: tb/tb_l1pa_regfile_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1pa_regfile_loader
// Brief    : Directed scenarios plus randomized traffic checked each cycle
//            against a job-level reference model of the loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1pa_regfile_loader;

    localparam int PAGE_NUM   = 32;
    localparam int PAGE_WIDTH = 15;
    localparam int ADDR_WIDTH = 5;
    localparam int CNT_WIDTH  = 6;

    logic                  sys_clk = 1'b0;
    logic                  rst;
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_addr_i;
    logic [CNT_WIDTH-1:0]  page_cnt_i;
    logic                  abort_i;
    logic [PAGE_WIDTH-1:0] pg_data_i;
    logic                  pg_valid_i;
    logic                  pg_ready_o;
    logic [ADDR_WIDTH-1:0] regType0_waddr_o;
    logic [PAGE_WIDTH-1:0] regType0_wdata_o;
    logic                  regType0_we_o;
    logic                  busy_o;
    logic                  done_o;
    logic [CNT_WIDTH-1:0]  pages_written_o;
    logic [PAGE_WIDTH-1:0] checksum_o;
    logic                  cfg_err_o;

    l1pa_regfile_loader #(
        .PAGE_NUM  (PAGE_NUM),
        .PAGE_WIDTH(PAGE_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .start_i         (start_i),
        .base_addr_i     (base_addr_i),
        .page_cnt_i      (page_cnt_i),
        .abort_i         (abort_i),
        .pg_data_i       (pg_data_i),
        .pg_valid_i      (pg_valid_i),
        .pg_ready_o      (pg_ready_o),
        .regType0_waddr_o(regType0_waddr_o),
        .regType0_wdata_o(regType0_wdata_o),
        .regType0_we_o   (regType0_we_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .pages_written_o (pages_written_o),
        .checksum_o      (checksum_o),
        .cfg_err_o       (cfg_err_o)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    // Job-level reference: phase 0 idle, 1 loading, 2 done.
    int                    mPhase;
    int                    mBase;
    int                    mJobLen;
    int                    mCount;
    logic [PAGE_WIDTH-1:0] mCsum;
    bit                    mErr;
    bit                    mWe;
    int                    mAddr;
    logic [PAGE_WIDTH-1:0] mData;

    int wlog[$];
    int doneSeen;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic mdlReset();
        mPhase = 0; mBase = 0; mJobLen = 0; mCount = 0;
        mCsum = '0; mErr = 1'b0; mWe = 1'b0; mAddr = 0; mData = '0;
    endtask

    task automatic mdlClock();
        if (rst) begin
            mdlReset();
            return;
        end
        mWe = 1'b0;
        case (mPhase)
            0: if (start_i) begin
                mCount  = 0;
                mCsum   = '0;
                mErr    = (int'(page_cnt_i) > PAGE_NUM);
                mJobLen = mErr ? PAGE_NUM : int'(page_cnt_i);
                mBase   = int'(base_addr_i);
                mPhase  = (mJobLen > 0) ? 1 : 2;
            end
            1: if (abort_i) begin
                mPhase = 0;
            end else if (pg_valid_i) begin
                mWe    = 1'b1;
                mAddr  = (mBase + mCount) % PAGE_NUM;
                mData  = pg_data_i;
                mCsum  = mCsum ^ pg_data_i;
                mCount = mCount + 1;
                if (mCount == mJobLen) mPhase = 2;
            end
            default: mPhase = 0;
        endcase
    endtask

    task automatic checkAll();
        cmp("pg_ready", 32'(pg_ready_o), 32'((mPhase == 1) && !abort_i));
        cmp("we", 32'(regType0_we_o), 32'(mWe));
        cmp("waddr", 32'(regType0_waddr_o), 32'(mAddr));
        cmp("wdata", 32'(regType0_wdata_o), 32'(mData));
        cmp("busy", 32'(busy_o), 32'(mPhase != 0));
        cmp("done", 32'(done_o), 32'(mPhase == 2));
        cmp("pages_written", 32'(pages_written_o), 32'(mCount));
        cmp("checksum", 32'(checksum_o), 32'(mCsum));
        cmp("cfg_err", 32'(cfg_err_o), 32'(mErr));
        if (regType0_we_o) wlog.push_back(int'(regType0_waddr_o));
        if (done_o) doneSeen++;
    endtask

    // Inputs are driven at the negedge before calling this.
    task automatic step();
        #1;
        checkAll();
        @(posedge sys_clk);
        mdlClock();
        @(negedge sys_clk);
    endtask

    task automatic idleIn();
        rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; pg_valid_i = 1'b0;
    endtask

    task automatic startJob(input int base, input int cnt);
        start_i = 1'b1; base_addr_i = ADDR_WIDTH'(base); page_cnt_i = CNT_WIDTH'(cnt);
        step();
        start_i = 1'b0;
    endtask

    task automatic sendPage(input bit v, input int d);
        pg_valid_i = v; pg_data_i = PAGE_WIDTH'(d);
        step();
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; pg_valid_i = 1'b0;
        base_addr_i = '0; page_cnt_i = '0; pg_data_i = '0;
        mdlReset();
        repeat (2) @(negedge sys_clk);
        step();
        cmp("reset_busy", 32'(busy_o), 32'd0);
        idleIn();
        step();

        // Basic load of five pages 0..4.
        wlog.delete(); doneSeen = 0;
        startJob(0, 5);
        for (int i = 0; i < 5; i++) sendPage(1'b1, i);
        pg_valid_i = 1'b0;
        repeat (3) step();
        cmp("basic_checksum_lit", 32'(checksum_o), 32'h4);
        cmp("basic_pages_lit", 32'(pages_written_o), 32'd5);
        cmp("basic_nwrites_lit", 32'(wlog.size()), 32'd5);
        cmp("basic_lastaddr_lit", 32'(wlog[4]), 32'd4);
        cmp("basic_done_lit", 32'(doneSeen), 32'd1);

        // Wrap-around from address 30.
        wlog.delete();
        startJob(30, 4);
        for (int i = 0; i < 4; i++) sendPage(1'b1, 'hA + i);
        pg_valid_i = 1'b0;
        repeat (3) step();
        cmp("wrap_n_lit", 32'(wlog.size()), 32'd4);
        cmp("wrap_a1_lit", 32'(wlog[1]), 32'd31);
        cmp("wrap_a2_lit", 32'(wlog[2]), 32'd0);
        cmp("wrap_a3_lit", 32'(wlog[3]), 32'd1);
        cmp("wrap_cfgerr_lit", 32'(cfg_err_o), 32'd0);

        // Bubbles on valid.
        startJob(3, 3);
        begin
            bit pat[6] = '{1, 0, 0, 1, 0, 1};
            for (int i = 0; i < 6; i++) sendPage(pat[i], 100 + i);
        end
        pg_valid_i = 1'b0;
        repeat (3) step();

        // Abort while the third page is offered.
        wlog.delete(); doneSeen = 0;
        startJob(10, 6);
        sendPage(1'b1, 7);
        sendPage(1'b1, 9);
        abort_i = 1'b1;
        sendPage(1'b1, 11);
        abort_i = 1'b0; pg_valid_i = 1'b0;
        repeat (2) step();
        cmp("abort_pages_lit", 32'(pages_written_o), 32'd2);
        cmp("abort_busy_lit", 32'(busy_o), 32'd0);
        cmp("abort_nodone_lit", 32'(doneSeen), 32'd0);
        cmp("abort_checksum_lit", 32'(checksum_o), 32'(7 ^ 9));

        // Oversize then zero-length.
        wlog.delete();
        startJob(5, 40);
        for (int i = 0; i < 36; i++) sendPage(1'b1, i * 3 + 1);
        pg_valid_i = 1'b0;
        repeat (2) step();
        cmp("oversize_err_lit", 32'(cfg_err_o), 32'd1);
        cmp("oversize_nwrites_lit", 32'(wlog.size()), 32'd32);
        wlog.delete(); doneSeen = 0;
        startJob(0, 0);
        repeat (3) step();
        cmp("zero_err_lit", 32'(cfg_err_o), 32'd0);
        cmp("zero_nwrites_lit", 32'(wlog.size()), 32'd0);
        cmp("zero_done_lit", 32'(doneSeen), 32'd1);

        // Reset in the middle of a job.
        startJob(2, 5);
        sendPage(1'b1, 21);
        sendPage(1'b1, 22);
        rst = 1'b1;
        sendPage(1'b1, 23);
        rst = 1'b0; pg_valid_i = 1'b0;
        cmp("rst_pages_lit", 32'(pages_written_o), 32'd0);
        cmp("rst_we_lit", 32'(regType0_we_o), 32'd0);
        step();
        wlog.delete();
        startJob(7, 1);
        sendPage(1'b1, 'h55);
        pg_valid_i = 1'b0;
        repeat (2) step();
        cmp("after_rst_n_lit", 32'(wlog.size()), 32'd1);
        cmp("after_rst_addr_lit", 32'(wlog[0]), 32'd7);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            start_i     = ($urandom_range(0, 5) == 0);
            base_addr_i = ADDR_WIDTH'($urandom_range(0, PAGE_NUM - 1));
            page_cnt_i  = CNT_WIDTH'($urandom_range(0, 41));
            abort_i     = ($urandom_range(0, 29) == 0);
            pg_valid_i  = ($urandom_range(0, 3) != 0);
            pg_data_i   = PAGE_WIDTH'($urandom);
            step();
        end
        idleIn();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
